tcu_core_req_responder: RTL and testbench

- Core-side responder for the TCU core-request protocol (CORE_REQ register plus CORE_REQ_INT register).
- Detects a pending request (INT register nonzero), reads and decodes CORE_REQ, and hands it to core-side logic over a valid/ready handshake.
- On acknowledge, writes the RESP type into CORE_REQ, then clears INT. This is what lets the TCU initiator reach FINISH and accept its next request.
- Acts as a register-interface master toward the TCU register file, in parallel with the TCU-internal master.

---
 rtl/tcu_core_req_pkg.sv | 37 +++
 rtl/tcu_core_req_responder_if.sv | 37 +++
 rtl/tcu_core_req_reg_master.sv | 35 +++
 rtl/tcu_core_req_responder.sv | 131 +++++++++++++
 tb/tb_tcu_core_req_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcu_core_req_pkg.sv
// Shared definitions for the TCU core-request protocol (initiator and responder sides).
// Type codes, CORE_REQ field layout, responder FSM encoding.
package tcu_core_req_pkg;

  typedef enum logic [2:0] {
    CORE_REQ_IDLE    = 3'd0,
    CORE_REQ_RESP    = 3'd1,
    CORE_REQ_FORMSG  = 3'd2,
    CORE_REQ_PMPFAIL = 3'd3
  } core_req_type_e;

  localparam int CORE_REQ_TYPE_LSB = 0;
  localparam int CORE_REQ_TYPE_W   = 3;
  localparam int FORMSG_EP_LSB     = 4;
  localparam int FORMSG_EP_W       = 16;
  localparam int FORMSG_VPEID_LSB  = 32;
  localparam int FORMSG_VPEID_W    = 16;
  localparam int PMP_WRITE_BIT     = 4;
  localparam int PMP_ERR_LSB       = 5;
  localparam int PMP_ERR_W         = 4;
  localparam int PMP_ADDR_LSB      = 32;
  localparam int PMP_ADDR_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_INT1, ST_RD_INT2, ST_RD_REQ1,
    ST_RD_REQ2, ST_PRESENT, ST_WR_RESP, ST_CLR_INT
  } core_req_state_e;

  function automatic logic is_core_req(input logic [2:0] t);
    return (t == CORE_REQ_FORMSG) || (t == CORE_REQ_PMPFAIL);
  endfunction

  function automatic logic is_stale(input logic [2:0] t);
    return (t == CORE_REQ_IDLE) || (t == CORE_REQ_RESP);
  endfunction

endpackage

// File: rtl/tcu_core_req_responder_if.sv
// Register-master bus toward the TCU register file plus the decoded-request handshake.
// master = responder side, slave = register file / core-side logic.
interface tcu_core_req_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BSEL_W = 8
) ();
  logic              rsp_reg_en_o;
  logic [BSEL_W-1:0] rsp_reg_wben_o;
  logic [ADDR_W-1:0] rsp_reg_addr_o;
  logic [DATA_W-1:0] rsp_reg_wdata_o;
  logic [DATA_W-1:0] rsp_reg_rdata_i;
  logic              rsp_reg_stall_i;
  logic              core_req_irq_i;
  logic              req_valid_o;
  logic [2:0]        req_type_o;
  logic [DATA_W-1:0] req_data_o;
  logic              req_ready_i;
  logic              busy_o;
  logic [7:0]        err_cnt_o;

  modport master (
    output rsp_reg_en_o, rsp_reg_wben_o, rsp_reg_addr_o, rsp_reg_wdata_o,
    input  rsp_reg_rdata_i, rsp_reg_stall_i, core_req_irq_i,
    output req_valid_o, req_type_o, req_data_o,
    input  req_ready_i,
    output busy_o, err_cnt_o
  );

  modport slave (
    input  rsp_reg_en_o, rsp_reg_wben_o, rsp_reg_addr_o, rsp_reg_wdata_o,
    output rsp_reg_rdata_i, rsp_reg_stall_i, core_req_irq_i,
    input  req_valid_o, req_type_o, req_data_o,
    output req_ready_i,
    input  busy_o, err_cnt_o
  );
endinterface

// File: rtl/tcu_core_req_reg_master.sv
// Single-outstanding register access sequencer: drives the bus while the caller holds the command.
// Accept is combinational (en & ~stall); read data strobe follows one cycle after an accepted read.
module tcu_core_req_reg_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BSEL_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_vld,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              reg_en,
  output logic [BSEL_W-1:0] reg_wben,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_stall,
  output logic              cmd_acc,
  output logic              rd_vld
);

  // Idle bus lines are forced to zero so nothing leaks out between accesses.
  assign reg_en    = cmd_vld;
  assign reg_wben  = (cmd_vld && cmd_wr) ? {BSEL_W{1'b1}} : '0;
  assign reg_addr  = cmd_vld ? cmd_addr : '0;
  assign reg_wdata = (cmd_vld && cmd_wr) ? cmd_wdata : '0;
  assign cmd_acc   = cmd_vld && !reg_stall;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rd_vld <= 1'b0;
    else         rd_vld <= cmd_acc && !cmd_wr;
  end

endmodule

// File: rtl/tcu_core_req_responder.sv
// Core-side responder: polls CORE_REQ_INT, decodes CORE_REQ, presents it, then writes RESP and clears INT.
// Request-to-valid ~5 cycles unstalled; valid holds until req_ready_i, bus stalls freeze the access.
module tcu_core_req_responder
  import tcu_core_req_pkg::*;
#(
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_DATA_SIZE = 64,
  parameter int TCU_REG_BSEL_SIZE = 8,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_REQ     = '0,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_REQ_INT = TCU_REGADDR_CORE_REQ + 'h8,
  parameter int POLL_INTERVAL = 16,
  parameter int POLL_CNT_SIZE = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  tcu_core_req_responder_if.master bus
);

  core_req_state_e                state_q, state_d;
  logic [POLL_CNT_SIZE-1:0]       poll_q, poll_d;
  logic [TCU_REG_DATA_SIZE-1:0]   req_data_q;
  logic [2:0]                     req_type_q;
  logic [7:0]                     err_cnt_q;
  logic                           busy_q;
  logic                           latch_req, err_inc;
  logic                           cmd_vld, cmd_wr, cmd_acc, rd_vld;
  logic [TCU_REG_ADDR_SIZE-1:0]   cmd_addr;
  logic [TCU_REG_DATA_SIZE-1:0]   cmd_wdata, rdata;

  assign rdata = bus.rsp_reg_rdata_i;

  tcu_core_req_reg_master #(
    .ADDR_W(TCU_REG_ADDR_SIZE), .DATA_W(TCU_REG_DATA_SIZE), .BSEL_W(TCU_REG_BSEL_SIZE)
  ) u_reg_master (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_vld(cmd_vld), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .reg_en(bus.rsp_reg_en_o), .reg_wben(bus.rsp_reg_wben_o),
    .reg_addr(bus.rsp_reg_addr_o), .reg_wdata(bus.rsp_reg_wdata_o),
    .reg_stall(bus.rsp_reg_stall_i), .cmd_acc(cmd_acc), .rd_vld(rd_vld)
  );

  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    cmd_vld   = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    latch_req = 1'b0;
    err_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.core_req_irq_i || poll_q == POLL_CNT_SIZE'(POLL_INTERVAL - 1)) begin
          state_d = ST_RD_INT1;
          poll_d  = '0;
        end else begin
          poll_d  = poll_q + POLL_CNT_SIZE'(1);
        end
      end
      ST_RD_INT1: begin
        cmd_vld  = 1'b1;
        cmd_addr = TCU_REGADDR_CORE_REQ_INT;
        if (cmd_acc) state_d = ST_RD_INT2;
      end
      ST_RD_INT2: begin
        if (rd_vld) state_d = (rdata == '0) ? ST_IDLE : ST_RD_REQ1;
      end
      ST_RD_REQ1: begin
        cmd_vld  = 1'b1;
        cmd_addr = TCU_REGADDR_CORE_REQ;
        if (cmd_acc) state_d = ST_RD_REQ2;
      end
      ST_RD_REQ2: begin
        if (rd_vld) begin
          latch_req = 1'b1;
          // Stale RESP/IDLE means the TCU has not published the new request yet: re-poll INT.
          if (is_core_req(rdata[2:0]))   state_d = ST_PRESENT;
          else if (is_stale(rdata[2:0])) state_d = ST_RD_INT1;
          else begin
            err_inc = 1'b1;
            state_d = ST_WR_RESP;
          end
        end
      end
      ST_PRESENT: begin
        if (bus.req_ready_i) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        cmd_vld   = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = TCU_REGADDR_CORE_REQ;
        cmd_wdata = TCU_REG_DATA_SIZE'(CORE_REQ_RESP);
        if (cmd_acc) state_d = ST_CLR_INT;
      end
      ST_CLR_INT: begin
        cmd_vld  = 1'b1;
        cmd_wr   = 1'b1;
        cmd_addr = TCU_REGADDR_CORE_REQ_INT;
        if (cmd_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      poll_q     <= '0;
      req_data_q <= '0;
      req_type_q <= '0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      busy_q  <= (state_q != ST_IDLE);
      if (latch_req) begin
        req_data_q <= rdata;
        req_type_q <= rdata[2:0];
      end
      if (err_inc && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.req_valid_o = (state_q == ST_PRESENT);
  assign bus.req_type_o  = req_type_q;
  assign bus.req_data_o  = req_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_tcu_core_req_responder.sv
// Bench for tcu_core_req_responder: register-file model, random stall/ready, scoreboard of presentations and writes.
module tb_tcu_core_req_responder;

  localparam logic [31:0] A_REQ = 32'h0;
  localparam logic [31:0] A_INT = 32'h8;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] tcu_req, tcu_int;
  bit          stall_en, ready_rand, irq_en;
  int          hold_cnt, errors, checks, int_rd_cnt, wr_cnt, err_model;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  tcu_core_req_responder_if #(.ADDR_W(32), .DATA_W(64), .BSEL_W(8)) bus ();

  tcu_core_req_responder #(
    .TCU_REG_ADDR_SIZE(32), .TCU_REG_DATA_SIZE(64), .TCU_REG_BSEL_SIZE(8),
    .TCU_REGADDR_CORE_REQ(32'h0), .TCU_REGADDR_CORE_REQ_INT(32'h8),
    .POLL_INTERVAL(16), .POLL_CNT_SIZE(8)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  assign bus.core_req_irq_i = irq_en && (tcu_int != 64'h0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: what the core side and the register file must see for one published request.
  task automatic expect_word(input logic [63:0] w);
    exp_t e;
    if (w[2:0] >= 3'd2) begin
      if (w[2:0] <= 3'd3) begin
        e.is_wr = 1'b0; e.addr = 32'h0; e.data = w;
        exp_q.push_back(e);
      end else if (err_model < 255) begin
        err_model++;
      end
      e.is_wr = 1'b1; e.addr = A_REQ; e.data = 64'h1;
      exp_q.push_back(e);
      e.is_wr = 1'b1; e.addr = A_INT; e.data = 64'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic publish(input logic [63:0] w);
    expect_word(w);
    tcu_req = w;
    tcu_int = 64'h1;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    while ((tcu_int != 64'h0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (tcu_int != 64'h0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: INT=%h pending=%0d after %0d cycles, required completion", name, tcu_int, exp_q.size(), n);
      exp_q.delete();
      tcu_int = 64'h0;
    end
  endtask

  // TCU register file and core-side driver
  initial begin
    logic        pend;
    logic [63:0] rd_val;
    bus.rsp_reg_rdata_i = '0;
    bus.rsp_reg_stall_i = 1'b0;
    bus.req_ready_i     = 1'b0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      rd_val = '0;
      if (!rst && bus.rsp_reg_en_o && !bus.rsp_reg_stall_i) begin
        if (bus.rsp_reg_wben_o != 8'h0) begin
          wr_cnt++;
          if (bus.rsp_reg_addr_o == A_REQ)      tcu_req = bus.rsp_reg_wdata_o;
          else if (bus.rsp_reg_addr_o == A_INT) tcu_int = bus.rsp_reg_wdata_o;
        end else begin
          pend = 1'b1;
          if (bus.rsp_reg_addr_o == A_INT) begin
            rd_val = tcu_int;
            int_rd_cnt++;
          end else if (bus.rsp_reg_addr_o == A_REQ) begin
            rd_val = tcu_req;
          end
        end
      end
      @(posedge clk); #1;
      bus.rsp_reg_rdata_i = pend ? rd_val : {$urandom, $urandom};
      bus.rsp_reg_stall_i = stall_en && ($urandom_range(0, 2) == 0);
      if (bus.req_valid_o && hold_cnt > 0) begin
        bus.req_ready_i = 1'b0;
        hold_cnt--;
      end else begin
        bus.req_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every presentation acceptance and every accepted write
  initial begin
    logic        pv, pr, pen, pst;
    logic [2:0]  pt;
    logic [63:0] pd, pwd;
    logic [31:0] pa;
    logic [7:0]  pw;
    pv = 0; pr = 0; pen = 0; pst = 0; pt = 0; pd = 0; pwd = 0; pa = 0; pw = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; pen = 0;
      end else begin
        if (pv && !pr) begin
          chk("valid_held", 64'(bus.req_valid_o), 64'h1);
          chk("type_held", 64'(bus.req_type_o), 64'(pt));
          chk("data_held", bus.req_data_o, pd);
        end
        if (pen && pst) begin
          chk("en_held", 64'(bus.rsp_reg_en_o), 64'h1);
          chk("addr_held", 64'(bus.rsp_reg_addr_o), 64'(pa));
          chk("wben_held", 64'(bus.rsp_reg_wben_o), 64'(pw));
          chk("wdata_held", bus.rsp_reg_wdata_o, pwd);
        end
        if (bus.req_valid_o && !pv) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].is_wr) begin
            errors++;
            $display("FAIL unexpected_valid: type=%0d data=%h presented, required no presentation", bus.req_type_o, bus.req_data_o);
          end
        end
        if (bus.req_valid_o && bus.req_ready_i) begin
          if (exp_q.size() != 0 && !exp_q[0].is_wr) begin
            chk("present_type", 64'(bus.req_type_o), 64'(exp_q[0].data[2:0]));
            chk("present_data", bus.req_data_o, exp_q[0].data);
            void'(exp_q.pop_front());
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: type=%0d data=%h accepted, required no presentation", bus.req_type_o, bus.req_data_o);
          end
        end
        if (bus.rsp_reg_en_o && !bus.rsp_reg_stall_i && bus.rsp_reg_wben_o != 8'h0) begin
          if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write here", bus.rsp_reg_addr_o, bus.rsp_reg_wdata_o);
          end else begin
            chk("write_addr", 64'(bus.rsp_reg_addr_o), 64'(exp_q[0].addr));
            chk("write_data", bus.rsp_reg_wdata_o, exp_q[0].data);
            chk("write_wben", 64'(bus.rsp_reg_wben_o), 64'hff);
            void'(exp_q.pop_front());
          end
        end
        pv = bus.req_valid_o; pr = bus.req_ready_i; pt = bus.req_type_o; pd = bus.req_data_o;
        pen = bus.rsp_reg_en_o; pst = bus.rsp_reg_stall_i; pa = bus.rsp_reg_addr_o;
        pw = bus.rsp_reg_wben_o; pwd = bus.rsp_reg_wdata_o;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, base, w0;
    logic [63:0] w;
    errors = 0; checks = 0; int_rd_cnt = 0; wr_cnt = 0; err_model = 0;
    tcu_req = '0; tcu_int = '0; stall_en = 0; ready_rand = 0; irq_en = 0; hold_cnt = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 64'(bus.req_valid_o), 64'h0);
    chk("rst_en", 64'(bus.rsp_reg_en_o), 64'h0);
    chk("rst_busy", 64'(bus.busy_o), 64'h0);
    chk("rst_err_cnt", 64'(bus.err_cnt_o), 64'h0);
    chk("rst_wben", 64'(bus.rsp_reg_wben_o), 64'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // FORMSG with irq, ready tied high, no stall
    irq_en = 1;
    publish(64'h0000_0005_0000_0102);
    wait_done("t1", 50, n);
    checks++;
    if (n > 9) begin
      errors++;
      $display("FAIL t1_latency: took %0d cycles, required <= 9", n);
    end
    chk("t1_core_req_resp", tcu_req, 64'h1);
    chk("t1_int_cleared", tcu_int, 64'h0);

    // Idle polling with INT=0: fixed period, no writes
    irq_en = 0;
    w0 = wr_cnt;
    base = int_rd_cnt; n = 0;
    while (int_rd_cnt == base && n < 60) begin @(posedge clk); #2; n++; end
    for (int k = 0; k < 3; k++) begin
      base = int_rd_cnt; n = 0;
      do begin @(posedge clk); #2; n++; end while (int_rd_cnt == base && n < 60);
      chk("t3_poll_period", 64'(n), 64'd18);
    end
    chk("t3_no_writes", 64'(wr_cnt - w0), 64'h0);

    // PMPFAIL, ready held low 20 cycles under random stall
    irq_en = 1; stall_en = 1; hold_cnt = 20;
    w0 = wr_cnt;
    publish(64'h8000_1000_0000_0053);
    wait_done("t2", 300, n);
    chk("t2_write_count", 64'(wr_cnt - w0), 64'd2);
    chk("t2_ready_hold_used", 64'(hold_cnt), 64'h0);

    // Stale RESP in CORE_REQ while INT=1: re-poll without presenting, then the real request
    stall_en = 0;
    base = int_rd_cnt;
    tcu_req = 64'h0000_0000_0000_0001;
    tcu_int = 64'h1;
    repeat (40) @(posedge clk);
    #2;
    checks++;
    if (int_rd_cnt - base < 3) begin
      errors++;
      $display("FAIL t5_repoll: %0d INT reads in 40 cycles, required >= 3", int_rd_cnt - base);
    end
    expect_word(64'h0000_0007_0000_0ab2);
    tcu_req = 64'h0000_0007_0000_0ab2;
    wait_done("t5", 100, n);

    // Unknown types: counted, never presented, still answered; counter saturates
    stall_en = 1;
    for (int i = 0; i < 300; i++) begin
      w = {$urandom, $urandom};
      w[2:0] = (i == 0) ? 3'd7 : 3'($urandom_range(4, 7));
      publish(w);
      wait_done("t4", 200, n);
      if (i == 0) chk("t4_err_first", 64'(bus.err_cnt_o), 64'd1);
    end
    chk("t4_err_sat", 64'(bus.err_cnt_o), 64'd255);
    chk("t4_err_model", 64'(bus.err_cnt_o), 64'(err_model));

    // Reset while presenting: valid drops at once, request is re-read after release
    stall_en = 0; hold_cnt = 1000;
    publish(64'h0000_0002_0000_0322);
    n = 0;
    while (!bus.req_valid_o && n < 50) begin @(posedge clk); #2; n++; end
    chk("t6_valid_seen", 64'(bus.req_valid_o), 64'h1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6_valid_async_drop", 64'(bus.req_valid_o), 64'h0);
    chk("t6_busy_reset", 64'(bus.busy_o), 64'h0);
    chk("t6_err_reset", 64'(bus.err_cnt_o), 64'h0);
    hold_cnt = 0;
    err_model = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("t6_int_still_set", tcu_int, 64'h1);
    rst = 1'b0;
    wait_done("t6", 100, n);

    // Random mix of request types, stall, ready and irq behaviour
    for (int i = 0; i < 40; i++) begin
      stall_en   = 1'($urandom_range(0, 1));
      ready_rand = 1'($urandom_range(0, 1));
      irq_en     = 1'($urandom_range(0, 1));
      hold_cnt   = $urandom_range(0, 5);
      w = {$urandom, $urandom};
      w[2:0] = 3'($urandom_range(2, 7));
      publish(w);
      wait_done("rand", 400, n);
      chk("rand_err_cnt", 64'(bus.err_cnt_o), 64'(err_model));
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
